// File: rtl/arith_pkg.sv
// Shared definitions for the ALU-side sequential arithmetic units
// (multiplier and divider): default width, FSM encoding, counter width.
package arith_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int CNT_W      = $clog2(DATA_WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE
  } arith_state_e;

endpackage

// File: rtl/div_datapath.sv
// Restoring-division datapath: divisor/remainder/quotient registers and the
// one-bit shift/subtract/restore step. Exposes the post-step Q and R values.
module div_datapath
  import arith_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] q_next_o,
  output logic [WIDTH-1:0] r_next_o
);

  logic [WIDTH-1:0] d_q, r_q, q_q;
  logic [WIDTH:0]   rs, t;

  // R never exceeds D-1 after a step, so its top bit is always zero and
  // only the low WIDTH bits are kept; the subtract itself is WIDTH+1 wide.
  always_comb begin
    rs       = {r_q, q_q[WIDTH-1]};
    t        = rs - {1'b0, d_q};
    q_next_o = {q_q[WIDTH-2:0], ~t[WIDTH]};
    r_next_o = t[WIDTH] ? rs[WIDTH-1:0] : t[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_q <= '0;
      r_q <= '0;
      q_q <= '0;
    end else if (load_i) begin
      d_q <= divisor_i;
      r_q <= '0;
      q_q <= dividend_i;
    end else if (step_i) begin
      r_q <= r_next_o;
      q_q <= q_next_o;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Unsigned sequential restoring divider, one quotient bit per clock, with the
// start/done handshake shared with the shift-add multiplier.
module seq_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic             ready,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  arith_state_e     state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, rem_q;
  logic             dbz_q;
  logic             accept, step, last_step, div_zero;
  logic [WIDTH-1:0] q_next, r_next;

  div_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk        (clk),
    .reset      (reset),
    .load_i     (accept),
    .step_i     (step),
    .dividend_i (dividend_in),
    .divisor_i  (divisor_in),
    .q_next_o   (q_next),
    .r_next_o   (r_next)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready     = (state_q == IDLE) || (state_q == DONE);
    done      = (state_q == DONE);
    accept    = start && ready;
    step      = (state_q == CALC);
    last_step = step && (cnt_q == CNT_LAST);
    div_zero  = (divisor_in == '0);
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          cnt_d   = '0;
          state_d = div_zero ? DONE : CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (last_step) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Divide-by-zero results are known at accept; normal ones at the last step.
      if (accept) begin
        dbz_q <= div_zero;
        if (div_zero) begin
          quot_q <= '1;
          rem_q  <= dividend_in;
        end
      end else if (last_step) begin
        quot_q <= q_next;
        rem_q  <= r_next;
        dbz_q  <= 1'b0;
      end
    end
  end

  assign div_by_zero   = dbz_q;
  assign quotient_out  = quot_q;
  assign remainder_out = rem_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=32): results, latency,
// done pulse width, divide-by-zero, ignored/accepted starts and mid-op reset.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend_in, divisor_in;
  logic        ready, done, div_by_zero;
  logic [31:0] quotient_out, remainder_out;

  int n_checks = 0;
  int n_errors = 0;
  int lat;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .dividend_in   (dividend_in),
    .divisor_in    (divisor_in),
    .ready         (ready),
    .done          (done),
    .div_by_zero   (div_by_zero),
    .quotient_out  (quotient_out),
    .remainder_out (remainder_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a start pulse; returns at the negedge one cycle after the accept edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start       = 1'b1;
    dividend_in = a;
    divisor_in  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles since the accept edge until done is seen (bounded).
  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic chk_res(input string tag, input logic [31:0] q, input logic [31:0] r,
                         input logic dbz);
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".q"}, quotient_out, q);
    chk({tag, ".r"}, remainder_out, r);
    chk({tag, ".dbz"}, 32'(div_by_zero), 32'(dbz));
    $display("op %s: %0d / %0d -> q=0x%0h r=0x%0h dbz=%0b lat=%0d",
             tag, dividend_in, divisor_in, quotient_out, remainder_out, div_by_zero, lat);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r, input logic dbz,
                        input int exp_lat);
    launch(a, b);
    wait_done(1, lat);
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk_res(tag, q, r, dbz);
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(done), 32'd0);
    chk({tag, ".ready"}, 32'(ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dividend_in = '0; divisor_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst.ready", 32'(ready), 32'd1);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.dbz", 32'(div_by_zero), 32'd0);
    chk("rst.q", quotient_out, 32'd0);
    chk("rst.r", remainder_out, 32'd0);

    run_op("t1", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    run_op("t2a", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    run_op("t2b", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 33);
    run_op("t3a", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 33);
    run_op("t3b", 32'd0, 32'd3, 32'd0, 32'd0, 1'b0, 33);
    run_op("t4a", 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1);

    // Accept clears div_by_zero at once but holds the old quotient/remainder.
    launch(32'd10, 32'd3);
    chk("t4b.dbzclr", 32'(div_by_zero), 32'd0);
    chk("t4b.qhold", quotient_out, 32'hFFFF_FFFF);
    chk("t4b.rhold", remainder_out, 32'd1234);
    wait_done(1, lat);
    chk("t4b.lat", 32'(lat), 32'd33);
    chk_res("t4b", 32'd3, 32'd1, 1'b0);

    // Start during CALC is ignored; start in the DONE cycle is accepted.
    launch(32'd100, 32'd7);
    repeat (9) @(negedge clk);
    chk("t5.busy", 32'(ready), 32'd0);
    start = 1'b1; dividend_in = 32'd50; divisor_in = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(11, lat);
    chk("t5a.lat", 32'(lat), 32'd33);
    chk_res("t5a", 32'd14, 32'd2, 1'b0);
    start = 1'b1; dividend_in = 32'd9; divisor_in = 32'd2;
    @(negedge clk);
    start = 1'b0;
    chk("t5b.acc", 32'(ready), 32'd0);
    chk("t5b.qhold", quotient_out, 32'd14);
    wait_done(1, lat);
    chk("t5b.lat", 32'(lat), 32'd33);
    chk_res("t5b", 32'd4, 32'd1, 1'b0);

    // Reset mid-operation discards it and clears the outputs.
    launch(32'd1000, 32'd3);
    repeat (13) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6.ready", 32'(ready), 32'd1);
    chk("t6.done", 32'(done), 32'd0);
    chk("t6.q", quotient_out, 32'd0);
    chk("t6.r", remainder_out, 32'd0);
    chk("t6.dbz", 32'(div_by_zero), 32'd0);
    run_op("t6b", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
